// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the requesting cores, the arbiter and the shared memory.
//   rd_en_i / wr_en_i : per-master read / write request
//   addr_i / data_i   : packed per-master address / write data (master k at slice k)
//   data_o / err_o    : read data and timeout flag, valid while ack_o is high
//   ack_o             : one-hot completion pulse
//   mem_*             : memory-side strobes, address, write data, read data, ack
// Modport slave is the arbiter's view; master is the cores + memory environment.
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            rd_en_i;
  logic [NUM_MASTERS-1:0]            wr_en_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0]             data_o;
  logic [NUM_MASTERS-1:0]            ack_o;
  logic                              err_o;
  logic                              mem_rd_en_o;
  logic                              mem_wr_en_o;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic [DATA_WIDTH-1:0]             mem_data_o;
  logic [DATA_WIDTH-1:0]             mem_data_i;
  logic                              mem_ack_i;

  modport slave (
    input  rd_en_i, wr_en_i, addr_i, data_i, mem_data_i, mem_ack_i,
    output data_o, ack_o, err_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );

  modport master (
    output rd_en_i, wr_en_i, addr_i, data_i, mem_data_i, mem_ack_i,
    input  data_o, ack_o, err_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting NUM_MASTERS cores access to one memory port,
// with an optional ACCESS timeout that completes the transfer with err_o.
// Ports: clk, rst_n (async, active-low), bus (mem_bus_arbiter_if.slave).
//
// state  | meaning
// IDLE   | waiting for any request; samples grant, op, address, write data
// ACCESS | memory strobe held until mem_ack_i or timeout
// RESP   | one-cycle ack_o pulse to the granted master
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD =
    (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, last_grant_q, pick;
  logic                   op_wr_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
  logic                   err_q;
  logic [TMR_W-1:0]       timer_q;
  logic [NUM_MASTERS-1:0] req;
  logic                   req_any, mem_done, timeout_hit;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];

  assign req         = bus.rd_en_i | bus.wr_en_i;
  assign req_any     = |req;
  assign mem_done    = (state_q == ACCESS) && bus.mem_ack_i;
  // Timer counts down from TIMEOUT_CYCLES-1, so reaching 0 marks the last allowed ACCESS cycle.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timer_q == '0);

  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      addr_arr[k]  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[k] = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round robin: first requester above last_grant, else lowest requester (wrap).
  always_comb begin : rr_pick
    logic             found_hi, found_lo;
    logic [IDX_W-1:0] pick_hi, pick_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found_hi && req[k] && (k > int'(last_grant_q))) begin
        pick_hi  = IDX_W'(k);
        found_hi = 1'b1;
      end
      if (!found_lo && req[k]) begin
        pick_lo  = IDX_W'(k);
        found_lo = 1'b1;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = ACCESS;
      ACCESS:  if (mem_done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            grant_q <= pick;
            op_wr_q <= bus.wr_en_i[pick];  // write wins when rd and wr are both set
            addr_q  <= addr_arr[pick];
            wdata_q <= wdata_arr[pick];
            timer_q <= TMR_LOAD;
          end
        end
        ACCESS: begin
          if (mem_done) begin
            rdata_q <= op_wr_q ? '0 : bus.mem_data_i;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        RESP: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_en_o = (state_q == ACCESS) && !op_wr_q;
  assign bus.mem_wr_en_o = (state_q == ACCESS) &&  op_wr_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_data_o  = wdata_q;
  assign bus.data_o      = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.ack_o       = (state_q == RESP) ? (NUM_MASTERS'(1) << grant_q) : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0, a1, d0, d1;
    int          lat;    // ACCESS cycles before mem_ack_i is raised
    logic [31:0] mrd;
    int          cyc;    // expected ACCESS cycles
    logic [1:0]  ack;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wd, e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input string nm, input int budget, output logic [1:0] a);
    int n;
    n = 0;
    a = '0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (bus.ack_o != '0) begin
        a = bus.ack_o;
        break;
      end
    end
    if (a == '0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no ack within %0d cycles expected an ack", nm, budget);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int    n;
    string p;
    p = $sformatf("v%0d", i);
    bus.rd_en_i = v.rd;
    bus.wr_en_i = v.wr;
    bus.addr_i  = {v.a1, v.a0};
    bus.data_i  = {v.d1, v.d0};
    @(posedge clk); #1;
    n = 0;
    while (bus.ack_o == '0 && n < 40) begin
      chk({p, "_rd_strobe"}, 64'(bus.mem_rd_en_o), 64'(v.e_rd));
      chk({p, "_wr_strobe"}, 64'(bus.mem_wr_en_o), 64'(v.e_wr));
      chk({p, "_mem_addr"},  64'(bus.mem_addr_o),  64'(v.e_addr));
      chk({p, "_mem_wdata"}, 64'(bus.mem_data_o),  64'(v.e_wd));
      if (n == v.lat) begin
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = v.mrd;
      end
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      n++;
    end
    chk({p, "_access_cycles"}, 64'(n), 64'(v.cyc));
    chk({p, "_ack"},  64'(bus.ack_o),  64'(v.ack));
    chk({p, "_data"}, 64'(bus.data_o), 64'(v.e_data));
    chk({p, "_err"},  64'(bus.err_o),  64'(v.e_err));
    bus.rd_en_i = '0;
    bus.wr_en_i = '0;
    @(posedge clk); #1;
    chk({p, "_ack_clear"},  64'(bus.ack_o),  64'd0);
    chk({p, "_data_hold"},  64'(bus.data_o), 64'(v.e_data));
    chk({p, "_err_hold"},   64'(bus.err_o),  64'(v.e_err));
    chk({p, "_strobe_off"}, 64'({bus.mem_rd_en_o, bus.mem_wr_en_o}), 64'd0);
  endtask

  initial begin
    logic [1:0] a, prev, exp_a;

    //          rd     wr     a0     a1     d0     d1     lat mrd           cyc ack    rd wr addr   wd     data          err
    vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0,  32'h0,  0,  32'hDEADBEEF, 1,  2'b01, 1, 0, 32'h10, 32'h0,  32'hDEADBEEF, 0};
    vecs[1] = '{2'b10, 2'b10, 32'h0,  32'h20, 32'h0,  32'h55, 0,  32'h0000FFFF, 1,  2'b10, 0, 1, 32'h20, 32'h55, 32'h0,        0};
    vecs[2] = '{2'b01, 2'b00, 32'h30, 32'h0,  32'h0,  32'h0,  4,  32'h12345678, 5,  2'b01, 1, 0, 32'h30, 32'h0,  32'h12345678, 0};
    vecs[3] = '{2'b00, 2'b10, 32'h0,  32'h44, 32'h0,  32'hA5A5, 99, 32'h0,      16, 2'b10, 0, 1, 32'h44, 32'hA5A5, 32'h0,      1};
    vecs[4] = '{2'b01, 2'b00, 32'h50, 32'h0,  32'h0,  32'h0,  0,  32'hCAFEF00D, 1,  2'b01, 1, 0, 32'h50, 32'h0,  32'hCAFEF00D, 0};
    vecs[5] = '{2'b11, 2'b00, 32'h60, 32'h64, 32'h0,  32'h0,  0,  32'h64646464, 1,  2'b10, 1, 0, 32'h64, 32'h0,  32'h64646464, 0};
    vecs[6] = '{2'b11, 2'b00, 32'h60, 32'h64, 32'h0,  32'h0,  0,  32'h60606060, 1,  2'b01, 1, 0, 32'h60, 32'h0,  32'h60606060, 0};
    vecs[7] = '{2'b00, 2'b10, 32'h0,  32'h70, 32'h11, 32'h77, 15, 32'h0BADBEEF, 16, 2'b10, 0, 1, 32'h70, 32'h77, 32'h0,        0};
    vecs[8] = '{2'b10, 2'b00, 32'h0,  32'h80, 32'h0,  32'h0,  0,  32'h80808080, 1,  2'b10, 1, 0, 32'h80, 32'h0,  32'h80808080, 0};
    vecs[9] = '{2'b00, 2'b01, 32'h90, 32'h94, 32'h99, 32'h22, 1,  32'hFFFFFFFF, 2,  2'b01, 0, 1, 32'h90, 32'h99, 32'h0,        0};

    rst_n          = 1'b0;
    bus.rd_en_i    = '0;
    bus.wr_en_i    = '0;
    bus.addr_i     = '0;
    bus.data_i     = '0;
    bus.mem_data_i = '0;
    bus.mem_ack_i  = 1'b0;
    #1;
    chk("rst_ack",    64'(bus.ack_o), 64'd0);
    chk("rst_strobe", 64'({bus.mem_rd_en_o, bus.mem_wr_en_o}), 64'd0);
    chk("rst_data",   64'(bus.data_o), 64'd0);
    chk("rst_err",    64'(bus.err_o), 64'd0);
    chk("rst_addr",   64'(bus.mem_addr_o), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // mem_ack_i held high while idle must be ignored; then continuous contention.
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 32'h0C0C0C0C;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ack_ignored",    64'(bus.ack_o), 64'd0);
      chk("idle_strobe_ignored", 64'({bus.mem_rd_en_o, bus.mem_wr_en_o}), 64'd0);
    end
    bus.rd_en_i = 2'b11;
    bus.addr_i  = {32'hB1, 32'hB0};
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0) ? 2'b10 : 2'b01;
      wait_ack($sformatf("contend%0d_wait", k), 10, a);
      chk($sformatf("contend%0d_grant", k), 64'(a), 64'(exp_a));
      chk($sformatf("contend%0d_alternates", k), 64'(a != prev), 64'd1);
      chk($sformatf("contend%0d_data", k), 64'(bus.data_o), 64'h0C0C0C0C);
      prev = a;
    end
    bus.rd_en_i   = '0;
    bus.mem_ack_i = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an ACCESS by master 1.
    bus.rd_en_i = 2'b10;
    bus.addr_i  = {32'hC4, 32'hC0};
    @(posedge clk); #1;
    chk("mid_rst_pre_strobe", 64'(bus.mem_rd_en_o), 64'd1);
    chk("mid_rst_pre_addr",   64'(bus.mem_addr_o), 64'hC4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe", 64'({bus.mem_rd_en_o, bus.mem_wr_en_o}), 64'd0);
    chk("mid_rst_ack",    64'(bus.ack_o), 64'd0);
    chk("mid_rst_data",   64'(bus.data_o), 64'd0);
    chk("mid_rst_addr",   64'(bus.mem_addr_o), 64'd0);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 32'h5A5A5A5A;
    @(posedge clk); #1;
    chk("mid_rst_hold_ack", 64'(bus.ack_o), 64'd0);
    bus.rd_en_i = 2'b11;
    @(negedge clk) rst_n = 1'b1;
    wait_ack("post_rst_wait", 10, a);
    chk("post_rst_grant", 64'(a), 64'b01);
    chk("post_rst_data",  64'(bus.data_o), 64'h5A5A5A5A);
    bus.rd_en_i   = '0;
    bus.mem_ack_i = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
